uart_tx_scheduler: RTL and testbench

- Sequences and shares the UART_System transmitter among NUM_REQ byte-producing requesters.
- After reset it writes the UART control register once (enable TX/RX).
- It then grants the TX channel round-robin, one byte per grant, and pulses tx_start.
- It waits for tx_done, acknowledges the winning requester, and recovers from a stalled transmitter by timeout.
- Sits between client logic and the UART_System wr_en/control_data/tx_start/tx_data/tx_done ports.

---
 rtl/uart_tx_scheduler.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// Writes the UART control register after reset and on request, and recovers from a stalled TX by timeout.
module uart_tx_scheduler #(
  parameter int         NUM_REQ   = 4,
  parameter logic [7:0] CTRL_INIT = 8'b00000011,
  parameter int         TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  input  logic                 cfg_req,
  input  logic [7:0]           cfg_data,
  output logic                 wr_en,
  output logic [7:0]           control_data,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_CFG,
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     cur_q, cur_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [NUM_REQ-1:0] grant_d, ack_d;
  logic              tx_start_d, wr_en_d, terr_d;
  logic [7:0]        ctrl_d, tx_data_d;

  logic [7:0]        byte_arr [NUM_REQ];
  logic [IW-1:0]     win_idx;
  logic              win_found;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign byte_arr[g] = req_data[8*g +: 8];
  end

  // Rotating priority: scan from the requester after the last owner.
  always_comb begin
    int            s;
    logic [IW-1:0] c;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      s = int'(last_q) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      c = IW'(s);
      if (!win_found && req[c]) begin
        win_found = 1'b1;
        win_idx   = c;
      end
    end
  end

  assign busy = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_DONE);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cur_d      = cur_q;
    timer_d    = timer_q;
    grant_d    = grant;
    ack_d      = '0;
    tx_start_d = 1'b0;
    wr_en_d    = 1'b0;
    terr_d     = 1'b0;
    ctrl_d     = control_data;
    tx_data_d  = tx_data;
    case (state_q)
      S_CFG: begin
        wr_en_d = 1'b1;
        ctrl_d  = CTRL_INIT;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        // The cycle carrying a control write does not arbitrate.
        if (!wr_en) begin
          if (cfg_req) begin
            wr_en_d = 1'b1;
            ctrl_d  = cfg_data;
          end else if (win_found) begin
            cur_d      = win_idx;
            grant_d    = onehot(win_idx);
            tx_data_d  = byte_arr[win_idx];
            tx_start_d = 1'b1;
            state_d    = S_START;
          end
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (tx_done) begin
          ack_d   = onehot(cur_q);
          state_d = S_DONE;
        end else if (timer_q == TMAX) begin
          terr_d  = 1'b1;
          grant_d = '0;
          last_d  = cur_q;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        grant_d = '0;
        last_d  = cur_q;
        state_d = S_IDLE;
      end
      default: state_d = S_CFG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CFG;
      last_q       <= IW'(NUM_REQ - 1);
      cur_q        <= '0;
      timer_q      <= '0;
      grant        <= '0;
      ack          <= '0;
      tx_start     <= 1'b0;
      wr_en        <= 1'b0;
      timeout_err  <= 1'b0;
      control_data <= '0;
      tx_data      <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cur_q        <= cur_d;
      timer_q      <= timer_d;
      grant        <= grant_d;
      ack          <= ack_d;
      tx_start     <= tx_start_d;
      wr_en        <= wr_en_d;
      timeout_err  <= terr_d;
      control_data <= ctrl_d;
      tx_data      <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: table of full transactions plus
// hand-written config, timeout and reset sequences.
module tb_uart_tx_scheduler;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req, ack, grant;
  logic [8*NR-1:0] req_data;
  logic            cfg_req, wr_en, tx_start, tx_done, busy, timeout_err;
  logic [7:0]      cfg_data, control_data, tx_data;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [NR-1:0] req;
    logic [31:0]   data;
    logic [NR-1:0] exp_g;
    logic [7:0]    exp_d;
    int            dly;
    logic          hold;
  } vec_t;

  vec_t tv [11];

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ  (NR),
    .CTRL_INIT(8'b00000011),
    .TIMEOUT  (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .grant       (grant),
    .cfg_req     (cfg_req),
    .cfg_data    (cfg_data),
    .wr_en       (wr_en),
    .control_data(control_data),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Starts in an arbitrating IDLE cycle, ends in the IDLE cycle after ack.
  task automatic xfer(input vec_t v, input int id);
    int strays;
    req      = v.req;
    req_data = v.data;
    step();
    chk($sformatf("v%0d tx_start", id), 32'(tx_start), 1);
    chk($sformatf("v%0d grant", id), 32'(grant), 32'(v.exp_g));
    chk($sformatf("v%0d tx_data", id), 32'(tx_data), 32'(v.exp_d));
    chk($sformatf("v%0d busy", id), 32'(busy), 1);
    if (!v.hold) req = '0;
    strays = 0;
    for (int i = 1; i <= v.dly; i++) begin
      step();
      if (tx_start || (ack != '0) || timeout_err) strays++;
    end
    chk($sformatf("v%0d stray pulses in wait", id), 32'(strays), 0);
    chk($sformatf("v%0d grant held", id), 32'(grant), 32'(v.exp_g));
    chk($sformatf("v%0d tx_data held", id), 32'(tx_data), 32'(v.exp_d));
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk($sformatf("v%0d ack", id), 32'(ack), 32'(v.exp_g));
    chk($sformatf("v%0d busy in done", id), 32'(busy), 1);
    step();
    chk($sformatf("v%0d ack clear", id), 32'(ack), 0);
    chk($sformatf("v%0d busy clear", id), 32'(busy), 0);
    chk($sformatf("v%0d grant clear", id), 32'(grant), 0);
  endtask

  initial begin
    int strays;
    tv[0]  = '{4'b0001, 32'h000000A5, 4'b0001, 8'hA5, 12, 1'b0};
    tv[1]  = '{4'b1111, 32'h43322110, 4'b0010, 8'h21, 3,  1'b1};
    tv[2]  = '{4'b1111, 32'h43322110, 4'b0100, 8'h32, 1,  1'b1};
    tv[3]  = '{4'b1111, 32'h43322110, 4'b1000, 8'h43, 5,  1'b1};
    tv[4]  = '{4'b1111, 32'h43322110, 4'b0001, 8'h10, 64, 1'b1};
    tv[5]  = '{4'b1111, 32'h43322110, 4'b0010, 8'h21, 2,  1'b1};
    tv[6]  = '{4'b1001, 32'h43322110, 4'b1000, 8'h43, 4,  1'b0};
    tv[7]  = '{4'b0110, 32'h43322110, 4'b0010, 8'h21, 2,  1'b1};
    tv[8]  = '{4'b0001, 32'h43322110, 4'b0001, 8'h10, 1,  1'b0};
    tv[9]  = '{4'b0110, 32'h43322110, 4'b0010, 8'h21, 2,  1'b0};
    tv[10] = '{4'b1001, 32'h43322110, 4'b1000, 8'h43, 3,  1'b0};

    rst = 1'b1; req = '0; req_data = '0; cfg_req = 1'b0; cfg_data = '0; tx_done = 1'b0;
    step(); step(); step();
    chk("reset wr_en", 32'(wr_en), 0);
    chk("reset grant", 32'(grant), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset control_data", 32'(control_data), 0);
    rst = 1'b0;
    step();
    chk("init wr_en", 32'(wr_en), 1);
    chk("init control_data", 32'(control_data), 32'h03);
    step();
    chk("init wr_en single", 32'(wr_en), 0);
    chk("init busy", 32'(busy), 0);
    chk("init grant", 32'(grant), 0);

    for (int i = 0; i <= 8; i++) xfer(tv[i], i);
    req = '0;

    // Config write wins over a same-cycle request; config during WAIT waits for IDLE.
    cfg_req = 1'b1; cfg_data = 8'h01; req = 4'b0010; req_data = 32'h43322110;
    step();
    chk("cfg wr_en", 32'(wr_en), 1);
    chk("cfg control_data", 32'(control_data), 32'h01);
    chk("cfg no start", 32'(tx_start), 0);
    chk("cfg no grant", 32'(grant), 0);
    cfg_req = 1'b0;
    step();
    chk("cfg wr_en single", 32'(wr_en), 0);
    chk("cfg control_data held", 32'(control_data), 32'h01);
    step();
    chk("cfg then start", 32'(tx_start), 1);
    chk("cfg then grant", 32'(grant), 32'b0010);
    req = '0; cfg_req = 1'b1; cfg_data = 8'h07;
    step();
    chk("cfg deferred wait", 32'(wr_en), 0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("cfg deferred ack", 32'(ack), 32'b0010);
    chk("cfg deferred done", 32'(wr_en), 0);
    step();
    chk("cfg deferred idle", 32'(wr_en), 0);
    step();
    chk("cfg late wr_en", 32'(wr_en), 1);
    chk("cfg late control_data", 32'(control_data), 32'h07);
    cfg_req = 1'b0;
    step();
    chk("cfg late single", 32'(wr_en), 0);
    chk("cfg late idle", 32'(busy), 0);

    // Reset in WAIT with a same-cycle tx_done: aborts with no ack.
    req = 4'b0100;
    step();
    chk("rstw grant", 32'(grant), 32'b0100);
    req = '0;
    step(); step();
    rst = 1'b1; tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("rstw grant", 32'(grant), 0);
    chk("rstw ack", 32'(ack), 0);
    chk("rstw tx_start", 32'(tx_start), 0);
    chk("rstw busy", 32'(busy), 0);
    chk("rstw tx_data", 32'(tx_data), 0);
    chk("rstw control_data", 32'(control_data), 0);
    step();
    chk("rstw ack hold", 32'(ack), 0);
    rst = 1'b0;
    step();
    chk("rstw cfg wr_en", 32'(wr_en), 1);
    chk("rstw cfg data", 32'(control_data), 32'h03);
    step();
    chk("rstw cfg single", 32'(wr_en), 0);
    xfer(tv[9], 9);

    // Stalled transmitter: timeout 64 cycles after WAIT entry, no ack.
    req = 4'b0100;
    step();
    chk("tmo grant", 32'(grant), 32'b0100);
    req = '0;
    strays = 0;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (timeout_err || (ack != '0) || tx_start) strays++;
    end
    chk("tmo early pulses", 32'(strays), 0);
    chk("tmo still busy", 32'(busy), 1);
    step();
    chk("tmo timeout_err", 32'(timeout_err), 1);
    chk("tmo grant clear", 32'(grant), 0);
    chk("tmo no ack", 32'(ack), 0);
    chk("tmo busy clear", 32'(busy), 0);
    step();
    chk("tmo pulse single", 32'(timeout_err), 0);
    xfer(tv[10], 10);
    req = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
